// File: rtl/tc_timer.sv
// tc_timer: memory-mapped 32-bit down-counting timer with masked IRQ.
// Define TC_PRESCALE_EN to step COUNT only every PRESCALE cycles.
module tc_timer #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_t;

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic [1:0]  sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        en;
  logic        reload;
  logic        tick;
  logic        unused_addr;

  assign sel       = Addr[3:2];
  assign wr_ctrl   = WE && (sel == 2'd0);
  assign wr_preset = WE && (sel == 2'd1);
  assign en        = ctrl[0];
  assign reload    = (ctrl[2:1] == 2'b01);

  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

`ifdef TC_PRESCALE_EN
  localparam int unsigned PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST =
    PW'(PRESCALE - 1);

  logic [PW-1:0] pre;

  assign tick = (pre == PS_LAST);

  // Prescaler runs only while counting; wraps on each step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (state == S_CNT && en && !tick) begin
      pre <= pre + 1'b1;
    end else begin
      pre <= '0;
    end
  end
`else
  // Without the prescaler every cycle is a step
  // (PRESCALE >= 1 always holds).
  assign tick = (PRESCALE >= 1);
`endif

  // Register file and timer FSM; a CPU CTRL write is applied last
  // so it wins over the FSM's En clear and irq_flag update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      if (wr_preset) begin
        preset <= Din;
      end

      unique case (state)
        S_IDLE: begin
          if (en) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!en) begin
            state <= S_IDLE;
          end else if (tick) begin
            if (count == '0) begin
              state    <= S_INT;
              irq_flag <= 1'b1;
            end else begin
              count <= count - 32'd1;
            end
          end
        end
        S_INT: begin
          state <= S_IDLE;
          if (reload) begin
            irq_flag <= 1'b0;
          end else begin
            ctrl[0] <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (wr_ctrl) begin
        ctrl     <= Din[3:0];
        irq_flag <= 1'b0;
      end
    end
  end

  // Zero-latency read mux.
  always_comb begin
    Dout = '0;
    unique case (sel)
      2'd0:    Dout = {28'b0, ctrl};
      2'd1:    Dout = preset;
      2'd2:    Dout = count;
      default: Dout = '0;
    endcase
  end

  assign IRQ = irq_flag & ctrl[3];

endmodule

// File: tb/tb_tc_timer.sv
// tb_tc_timer: directed bench for tc_timer.
// Expected values go through a scoreboard queue.
module tb_tc_timer;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  tc_timer #(.PRESCALE(4)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    WE   = 1'b0;
    Addr = '0;
  endtask

  task automatic push_exp(input string t,
                          input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: observed %h expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h",
               e.tag, obs, e.val);
      end
    end
  endtask

  task automatic rchk(input string t,
                      input logic [31:0] a,
                      input logic [31:0] v);
    push_exp(t, v);
    Addr = a;
    #1;
    chk(Dout);
  endtask

  task automatic ichk(input string t, input logic v);
    push_exp(t, {31'b0, v});
    chk({31'b0, IRQ});
  endtask

  initial begin
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = '0;
    Din   = '0;

    cyc(2);
    rchk("rst_ctrl", 32'h0, 32'h0);
    rchk("rst_preset", 32'h4, 32'h0);
    rchk("rst_count", 32'h8, 32'h0);
    rchk("rst_rsvd", 32'hC, 32'h0);
    ichk("rst_irq", 1'b0);
    reset = 1'b0;
    cyc(1);

`ifdef TC_PRESCALE_EN
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h9);
    for (int e = 1; e <= 15; e++) begin
      logic [31:0] ce;
      cyc(1);
      ce = (e < 2) ? 32'd0 :
           (e < 6) ? 32'd2 :
           (e < 10) ? 32'd1 : 32'd0;
      rchk("ps_count", 32'h8, ce);
      ichk("ps_irq", e >= 14);
    end
    wr(32'h0, 32'h0);
    cyc(3);
`else
    wr(32'h4, 32'd5);
    wr(32'h0, 32'h9);
    cyc(2);
    rchk("os_count_load", 32'h8, 32'd5);
    for (int k = 4; k >= 0; k--) begin
      cyc(1);
      rchk("os_count", 32'h8, k);
      ichk("os_irq_low", 1'b0);
    end
    cyc(1);
    ichk("os_irq_rise", 1'b1);
    rchk("os_count_zero", 32'h8, 32'd0);
    rchk("os_ctrl_exp", 32'h0, 32'h9);
    cyc(1);
    rchk("os_ctrl_done", 32'h0, 32'h8);
    ichk("os_irq_held", 1'b1);
    cyc(3);
    ichk("os_irq_held2", 1'b1);
    rchk("os_count_stop", 32'h8, 32'd0);
    wr(32'h0, 32'h8);
    ichk("os_irq_clr", 1'b0);
    rchk("os_ctrl_clr", 32'h0, 32'h8);

    wr(32'h4, 32'd3);
    wr(32'h0, 32'hB);
    for (int e = 1; e <= 21; e++) begin
      cyc(1);
      ichk("ar_irq", (e == 6) || (e == 13) || (e == 20));
      if (e == 2 || e == 9 || e == 16)
        rchk("ar_count", 32'h8, 32'd3);
    end
    rchk("ar_ctrl", 32'h0, 32'hB);
    wr(32'h0, 32'h0);
    cyc(3);

    wr(32'h4, 32'd2);
    wr(32'h0, 32'h1);
    for (int e = 1; e <= 8; e++) begin
      cyc(1);
      ichk("mask_irq", 1'b0);
    end
    rchk("mask_ctrl", 32'h0, 32'h0);

    wr(32'h4, 32'd10);
    wr(32'h0, 32'h1);
    cyc(3);
    rchk("stop_count9", 32'h8, 32'd9);
    wr(32'h4, 32'd20);
    rchk("pre_mid_count", 32'h8, 32'd8);
    cyc(1);
    rchk("stop_count7", 32'h8, 32'd7);
    wr(32'h0, 32'h0);
    rchk("stop_count6", 32'h8, 32'd6);
    cyc(3);
    rchk("stop_hold", 32'h8, 32'd6);
    rchk("stop_preset", 32'h4, 32'd20);

    wr(32'h4, 32'd2);
    wr(32'h0, 32'h9);
    cyc(5);
    ichk("col_irq_rise", 1'b1);
    wr(32'h0, 32'h9);
    ichk("col_int_irq", 1'b0);
    rchk("col_int_ctrl", 32'h0, 32'h9);
    cyc(4);
    rchk("col_count", 32'h8, 32'd0);
    wr(32'h0, 32'h9);
    ichk("col_exp_irq", 1'b0);
    cyc(1);
    rchk("col_exp_ctrl", 32'h0, 32'h8);
    ichk("col_exp_irq2", 1'b0);

    wr(32'h8, 32'h55);
    rchk("dec_count_ro", 32'h8, 32'd0);
    wr(32'hC, 32'hFFFF_FFFF);
    rchk("dec_rsvd", 32'hC, 32'h0);
    rchk("dec_ctrl", 32'h0, 32'h8);
    rchk("dec_preset", 32'h4, 32'd2);
`endif

    wr(32'h4, 32'd5);
    wr(32'h0, 32'h9);
`ifdef TC_PRESCALE_EN
    cyc(2 + 6 * 4);
`else
    cyc(8);
`endif
    ichk("mid_pre_irq", 1'b1);
    #1;
    reset = 1'b1;
    #1;
    ichk("mid_rst_irq", 1'b0);
    rchk("mid_rst_ctrl", 32'h0, 32'h0);
    rchk("mid_rst_preset", 32'h4, 32'h0);
    rchk("mid_rst_count", 32'h8, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
